// File: rtl/i2c_master_ctrl.sv
// Transaction-level I2C master: owns SCL timing, START/STOP and address/write shifting,
// and hands read bytes to an external byte receiver whose SDA drive it forwards.
module i2c_master_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CLK_DIV  = CLK_FREQ / 200_000,
    parameter int DIV_LEN  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [6:0]         cmd_addr,
    input  logic               cmd_rw,
    input  logic [3:0]         cmd_len,
    input  logic [7:0]         wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               done,
    output logic               nack_err,
    output logic               scl_o,
    input  logic               sda_o,
    output logic               sda_t,
    output logic               sda_i,
    output logic [DIV_LEN-1:0] clk_counter,
    output logic               rx,
    input  logic [7:0]         rx_data,
    input  logic               rx_data_rdy,
    output logic               rx_ack,
    input  logic               rx_sda_t,
    input  logic               rx_sda_i
);
    localparam logic [2:0] kIdle     = 3'd0;
    localparam logic [2:0] kStart    = 3'd1;
    localparam logic [2:0] kAddr     = 3'd2;
    localparam logic [2:0] kAddrAck  = 3'd3;
    localparam logic [2:0] kWrite    = 3'd4;
    localparam logic [2:0] kWriteAck = 3'd5;
    localparam logic [2:0] kRead     = 3'd6;
    localparam logic [2:0] kStop     = 3'd7;

    localparam logic [DIV_LEN-1:0] DIV_MAX = DIV_LEN'(CLK_DIV - 1);
    localparam logic [DIV_LEN-1:0] DIV_MID = DIV_LEN'(CLK_DIV / 2);

    logic [2:0]         state_q, state_d;
    logic [DIV_LEN-1:0] cnt_q, cnt_d;
    logic               scl_q, scl_d, sda_t_q, sda_t_d, sda_i_q, sda_i_d;
    logic [7:0]         sh_q, sh_d, rd_data_q, rd_data_d;
    logic [3:0]         bit_q, bit_d, rem_q, rem_d;
    logic               rw_q, rw_d, ack_q, ack_d, nack_q, nack_d;
    logic               rx_q, rx_d, rx_ack_q, rx_ack_d;
    logic               rd_valid_q, rd_valid_d, done_q, done_d, rdy_q;

    logic wrap, chg, smp, bit_end, first_chg, stall, fwd;

    assign wrap      = (cnt_q == DIV_MAX);
    assign chg       = (cnt_q == DIV_MID) && !scl_q;
    assign smp       = (cnt_q == DIV_MID) && scl_q;
    assign bit_end   = wrap && scl_q;
    // A write byte is fetched at its first change point; with no data the bus parks there.
    assign first_chg = (state_q == kWrite) && (bit_q == 4'd7) && chg;
    assign stall     = first_chg && !wr_valid;
    assign fwd       = (state_q == kRead) && !rx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scl_d      = scl_q;
        sda_t_d    = sda_t_q;
        sda_i_d    = sda_i_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        rem_d      = rem_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        nack_d     = nack_q;
        rx_d       = rx_q;
        rx_ack_d   = rx_ack_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;

        if (state_q == kIdle) cnt_d = '0;
        else if (!stall)      cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap && (state_q inside {kAddr, kAddrAck, kWrite, kWriteAck, kRead})) scl_d = !scl_q;

        case (state_q)
            kIdle: if (cmd_valid) begin
                sh_d    = {cmd_addr, cmd_rw};
                rw_d    = cmd_rw;
                rem_d   = cmd_len;
                nack_d  = 1'b0;
                sda_t_d = 1'b0;
                sda_i_d = 1'b0;
                state_d = kStart;
            end
            kStart: if (wrap) begin
                scl_d   = 1'b0;
                bit_d   = 4'd7;
                state_d = kAddr;
            end
            kAddr, kWrite: begin
                if (chg) begin
                    if (state_q == kWrite && bit_q == 4'd7) begin
                        if (wr_valid) begin
                            sh_d    = wr_data;
                            sda_t_d = 1'b0;
                            sda_i_d = wr_data[7];
                        end
                    end else begin
                        sda_t_d = 1'b0;
                        sda_i_d = sh_q[7];
                    end
                end
                if (bit_end) begin
                    if (bit_q == 4'd0) state_d = (state_q == kAddr) ? kAddrAck : kWriteAck;
                    else begin
                        bit_d = bit_q - 4'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                    end
                end
            end
            kAddrAck, kWriteAck: begin
                if (chg) begin
                    sda_t_d = 1'b1;
                    sda_i_d = 1'b1;
                end
                if (smp) ack_d = sda_o;
                if (bit_end) begin
                    bit_d = 4'd7;
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = kStop;
                    end else if (state_q == kAddrAck) begin
                        if (rem_q == 4'd0) state_d = kStop;
                        else if (rw_q) begin
                            bit_d    = 4'd8;
                            rx_d     = 1'b0;
                            rx_ack_d = (rem_q == 4'd1);
                            state_d  = kRead;
                        end else state_d = kWrite;
                    end else if (rem_q == 4'd1) state_d = kStop;
                    else begin
                        rem_d   = rem_q - 4'd1;
                        state_d = kWrite;
                    end
                end
            end
            kRead: begin
                if (rdy_q && !rx_data_rdy) begin
                    rd_data_d  = rx_data;
                    rd_valid_d = 1'b1;
                end
                // Nine slots per byte; the final NACK slot is ours (released), not the receiver's.
                if (bit_end) begin
                    if (bit_q == 4'd1 && rem_q == 4'd1) rx_d = 1'b1;
                    if (bit_q == 4'd0) begin
                        if (rem_q == 4'd1) begin
                            rx_d     = 1'b1;
                            rx_ack_d = 1'b1;
                            state_d  = kStop;
                        end else begin
                            rem_d    = rem_q - 4'd1;
                            bit_d    = 4'd8;
                            rx_ack_d = (rem_q == 4'd2);
                        end
                    end else bit_d = bit_q - 4'd1;
                end
            end
            kStop: begin
                if (chg) begin
                    sda_t_d = 1'b0;
                    sda_i_d = 1'b0;
                end
                if (wrap) scl_d = 1'b1;
                if (smp) begin
                    sda_t_d = 1'b1;
                    sda_i_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = kIdle;
                end
            end
            default: state_d = kIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= kIdle;
            cnt_q      <= '0;
            scl_q      <= 1'b1;
            sda_t_q    <= 1'b1;
            sda_i_q    <= 1'b1;
            sh_q       <= '0;
            bit_q      <= '0;
            rem_q      <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            rx_q       <= 1'b1;
            rx_ack_q   <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scl_q      <= scl_d;
            sda_t_q    <= sda_t_d;
            sda_i_q    <= sda_i_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            rem_q      <= rem_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            rx_q       <= rx_d;
            rx_ack_q   <= rx_ack_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            rdy_q      <= rx_data_rdy;
        end
    end

    assign cmd_ready   = (state_q == kIdle);
    assign busy        = (state_q != kIdle);
    assign wr_ready    = first_chg && wr_valid;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign nack_err    = nack_q;
    assign scl_o       = scl_q;
    assign sda_t       = fwd ? rx_sda_t : sda_t_q;
    assign sda_i       = fwd ? rx_sda_i : sda_i_q;
    assign clk_counter = cnt_q;
    assign rx          = rx_q;
    assign rx_ack      = rx_ack_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: bus monitor, I2C slave model and byte-receiver model.
module tb_i2c_master_ctrl;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [7:0]  wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, busy, done, nack_err;
    logic        scl_o, sda_o, sda_t, sda_i, rx, rx_ack;
    logic [15:0] clk_counter;
    logic [7:0]  rx_data = '0;
    logic        rx_data_rdy = 1'b1, rx_sda_t = 1'b1, rx_sda_i = 1'b1;

    i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .nack_err(nack_err), .scl_o(scl_o), .sda_o(sda_o), .sda_t(sda_t),
        .sda_i(sda_i), .clk_counter(clk_counter), .rx(rx), .rx_data(rx_data),
        .rx_data_rdy(rx_data_rdy), .rx_ack(rx_ack), .rx_sda_t(rx_sda_t),
        .rx_sda_i(rx_sda_i)
    );

    int tests = 0, fails = 0;

    // scenario knobs
    logic       clr = 1'b0, wr_en = 1'b0, wr_hold = 1'b0, ack_addr = 1'b1;
    logic [2:0] nack_fr = '0, rd_n = '0, wlen = '0;
    logic [7:0] wdata [0:7];
    logic [7:0] rd_bytes [0:7];

    // host write side
    logic [2:0] widx = '0;
    int         n_wrr = 0, n_done = 0;
    assign wr_data  = wdata[widx];
    assign wr_valid = wr_en && (widx < wlen) && !(wr_hold && widx == 3'd1);

    always @(posedge clk) begin
        if (clr) begin
            widx   <= '0;
            n_wrr  <= 0;
            n_done <= 0;
        end else begin
            if (wr_ready) begin
                widx  <= widx + 3'd1;
                n_wrr <= n_wrr + 1;
            end
            if (done) n_done <= n_done + 1;
        end
    end

    // wired-AND bus and slave drive
    logic sda_line, slv_sda;
    assign sda_line = (sda_t ? 1'b1 : sda_i) & slv_sda;
    assign sda_o    = sda_line;

    logic       pscl = 1'b1, psda = 1'b1, act = 1'b0;
    logic [3:0] bitn = '0, slot = '0;
    logic [2:0] fr = '0, nrd = '0;
    logic [7:0] msh = '0;
    logic [7:0] mbytes [0:7];
    logic       macks [0:7];
    logic [7:0] rd_got [0:7];
    logic       ack_got [0:7];
    int         n_start = 0, n_stop = 0;

    always_comb begin
        slv_sda = 1'b1;
        if (act) begin
            if (fr == 3'd0) begin
                if (slot == 4'd8) slv_sda = !ack_addr;
            end else if (mbytes[0][0]) begin
                if (slot < 4'd8 && fr <= rd_n) slv_sda = rd_bytes[fr - 3'd1][3'd7 - slot[2:0]];
            end else if (slot == 4'd8) slv_sda = (fr == nack_fr);
        end
    end

    always @(negedge clk) begin
        pscl <= scl_o;
        psda <= sda_line;
        if (clr) begin
            act <= 1'b0; bitn <= '0; slot <= '0; fr <= '0;
            n_start <= 0; n_stop <= 0; nrd <= '0;
        end else begin
            if (rd_valid) begin
                rd_got[nrd]  <= rd_data;
                ack_got[nrd] <= rx_ack;
                nrd          <= nrd + 3'd1;
            end
            if (pscl && scl_o && psda && !sda_line) begin
                n_start <= n_start + 1;
                act <= 1'b1; bitn <= '0; slot <= '0; fr <= '0;
            end else if (pscl && scl_o && !psda && sda_line) begin
                n_stop <= n_stop + 1;
                act    <= 1'b0;
            end else if (!pscl && scl_o) begin
                msh  <= {msh[6:0], sda_line};
                bitn <= bitn + 4'd1;
                if (bitn == 4'd7) mbytes[fr] <= {msh[6:0], sda_line};
                if (bitn == 4'd8) macks[fr] <= sda_line;
            end else if (pscl && !scl_o) begin
                if (bitn == 4'd9) begin
                    bitn <= '0; slot <= '0; fr <= fr + 3'd1;
                end else slot <= bitn;
            end
        end
    end

    // byte receiver model: 8 data bits, then drives rx_ack in the ACK slot
    logic [3:0] rcnt = '0;
    logic [7:0] rsh = '0;
    always @(negedge clk) begin
        if (rx) begin
            rcnt <= '0; rx_sda_t <= 1'b1; rx_data_rdy <= 1'b1;
        end else begin
            rx_data_rdy <= 1'b1;
            if (!pscl && scl_o) begin
                rsh  <= {rsh[6:0], sda_line};
                rcnt <= rcnt + 4'd1;
                if (rcnt == 4'd7) begin
                    rx_data     <= {rsh[6:0], sda_line};
                    rx_data_rdy <= 1'b0;
                end
            end else if (pscl && !scl_o) begin
                if (rcnt == 4'd8) begin
                    rx_sda_t <= 1'b0; rx_sda_i <= rx_ack;
                end else if (rcnt == 4'd9) begin
                    rcnt <= '0; rx_sda_t <= 1'b1;
                end
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic issue(input logic [6:0] a, input logic rw, input logic [3:0] len);
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_len = len; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || nack_err !== 1'b0) begin
            fails++;
            $display("FAIL accept: busy=%b nack_err=%b, required busy=1 nack_err=0", busy, nack_err);
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_timeout: no done pulse within 6000 cycles", nm);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({scl_o, sda_t, sda_i, rx, rx_ack, busy, cmd_ready, wr_ready, rd_valid, done, nack_err}
            !== 11'b11111_0_1_0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 11111010000",
                     {scl_o, sda_t, sda_i, rx, rx_ack, busy, cmd_ready, wr_ready, rd_valid, done, nack_err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (clk_counter !== 16'd0 || rd_data !== 8'h00 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_data: cnt=%0d rd_data=%h ready=%b, required 0 00 1", clk_counter, rd_data, cmd_ready);
        end
    endtask

    task automatic test_write();
        clear_mon();
        wdata[0] = 8'h12; wdata[1] = 8'h34; wlen = 3'd2; wr_en = 1'b1;
        ack_addr = 1'b1; nack_fr = '0;
        issue(7'h50, 1'b0, 4'd2);
        wait_done("write");
        tests++;
        if (mbytes[0] !== 8'hA0 || mbytes[1] !== 8'h12 || mbytes[2] !== 8'h34) begin
            fails++;
            $display("FAIL write_bytes: got %h %h %h required a0 12 34", mbytes[0], mbytes[1], mbytes[2]);
        end
        tests++;
        if (n_start !== 1 || n_stop !== 1 || n_wrr !== 2 || n_done !== 1) begin
            fails++;
            $display("FAIL write_ctrl: start=%0d stop=%0d wr_ready=%0d done=%0d required 1 1 2 1", n_start, n_stop, n_wrr, n_done);
        end
        tests++;
        if (nack_err !== 1'b0 || busy !== 1'b0 || scl_o !== 1'b1 || sda_t !== 1'b1) begin
            fails++;
            $display("FAIL write_end: nack=%b busy=%b scl=%b sda_t=%b required 0 0 1 1", nack_err, busy, scl_o, sda_t);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_addr_nack();
        clear_mon();
        wdata[0] = 8'h99; wlen = 3'd1; wr_en = 1'b1; ack_addr = 1'b0;
        issue(7'h3C, 1'b0, 4'd1);
        wait_done("addr_nack");
        tests++;
        if (nack_err !== 1'b1 || mbytes[0] !== 8'h78) begin
            fails++;
            $display("FAIL nack_flag: nack=%b byte=%h required 1 78", nack_err, mbytes[0]);
        end
        tests++;
        if (n_stop !== 1 || n_wrr !== 0 || n_done !== 1) begin
            fails++;
            $display("FAIL nack_ctrl: stop=%0d wr_ready=%0d done=%0d required 1 0 1", n_stop, n_wrr, n_done);
        end
        wr_en = 1'b0; ack_addr = 1'b1;
    endtask

    task automatic test_read();
        clear_mon();
        rd_bytes[0] = 8'hDE; rd_bytes[1] = 8'hAD; rd_bytes[2] = 8'hBE; rd_n = 3'd3;
        issue(7'h51, 1'b1, 4'd3);
        wait_done("read");
        tests++;
        if (mbytes[0] !== 8'hA3 || nrd !== 3'd3) begin
            fails++;
            $display("FAIL read_hdr: addr byte=%h rd_valid count=%0d required a3 3", mbytes[0], nrd);
        end
        tests++;
        if (rd_got[0] !== 8'hDE || rd_got[1] !== 8'hAD || rd_got[2] !== 8'hBE) begin
            fails++;
            $display("FAIL read_data: got %h %h %h required de ad be", rd_got[0], rd_got[1], rd_got[2]);
        end
        tests++;
        if ({ack_got[0], ack_got[1], ack_got[2]} !== 3'b001 ||
            {macks[1], macks[2], macks[3]} !== 3'b001) begin
            fails++;
            $display("FAIL read_ack: rx_ack=%b%b%b bus=%b%b%b required 001 001", ack_got[0], ack_got[1],
                     ack_got[2], macks[1], macks[2], macks[3]);
        end
        tests++;
        if (n_stop !== 1 || n_done !== 1 || nack_err !== 1'b0 || rx !== 1'b1) begin
            fails++;
            $display("FAIL read_end: stop=%0d done=%0d nack=%b rx=%b required 1 1 0 1", n_stop, n_done, nack_err, rx);
        end
        rd_n = '0;
    endtask

    task automatic test_probe();
        clear_mon();
        issue(7'h20, 1'b0, 4'd0);
        wait_done("probe");
        tests++;
        if (mbytes[0] !== 8'h40 || macks[0] !== 1'b0 || n_start !== 1 || n_stop !== 1) begin
            fails++;
            $display("FAIL probe_bus: byte=%h ack=%b start=%0d stop=%0d required 40 0 1 1",
                     mbytes[0], macks[0], n_start, n_stop);
        end
        tests++;
        if (nack_err !== 1'b0 || n_wrr !== 0 || nrd !== 3'd0) begin
            fails++;
            $display("FAIL probe_ctrl: nack=%b wr_ready=%0d rd=%0d required 0 0 0", nack_err, n_wrr, nrd);
        end
    endtask

    task automatic test_stall();
        bit got = 0;
        logic [15:0] c1;
        clear_mon();
        wdata[0] = 8'h5A; wdata[1] = 8'hC3; wlen = 3'd2; wr_en = 1'b1; wr_hold = 1'b1;
        issue(7'h50, 1'b0, 4'd2);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (widx == 3'd1) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL stall_first_byte: byte 1 not consumed within 2000 cycles");
        end
        repeat (500) @(negedge clk);
        c1 = clk_counter;
        repeat (500) @(negedge clk);
        tests++;
        if (scl_o !== 1'b0 || clk_counter !== 16'(DIV / 2) || c1 !== 16'(DIV / 2) || busy !== 1'b1 || widx !== 3'd1) begin
            fails++;
            $display("FAIL stall_hold: scl=%b cnt=%0d/%0d busy=%b idx=%0d required 0 %0d/%0d 1 1",
                     scl_o, c1, clk_counter, busy, widx, DIV / 2, DIV / 2);
        end
        wr_hold = 1'b0;
        wait_done("stall");
        tests++;
        if (mbytes[1] !== 8'h5A || mbytes[2] !== 8'hC3 || n_wrr !== 2 || n_stop !== 1 || nack_err !== 1'b0) begin
            fails++;
            $display("FAIL stall_resume: got %h %h wr_ready=%0d stop=%0d nack=%b required 5a c3 2 1 0",
                     mbytes[1], mbytes[2], n_wrr, n_stop, nack_err);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        clear_mon();
        wdata[0] = 8'hF0; wdata[1] = 8'h0F; wlen = 3'd2; wr_en = 1'b1;
        issue(7'h50, 1'b0, 4'd2);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (widx == 3'd1) got = 1;
        end
        repeat (40) @(negedge clk);
        for (int i = 0; i < 50 && scl_o !== 1'b0; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (scl_o !== 1'b1 || sda_t !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || clk_counter !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid: scl=%b sda_t=%b busy=%b ready=%b cnt=%0d required 1 1 0 1 0",
                     scl_o, sda_t, busy, cmd_ready, clk_counter);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (n_stop !== 0 || n_done !== 0 || !got) begin
            fails++;
            $display("FAIL rst_mid_nostop: stop=%0d done=%0d started=%0d required 0 0 1", n_stop, n_done, got);
        end
        clear_mon();
        wdata[0] = 8'h77; wlen = 3'd1;
        issue(7'h50, 1'b0, 4'd1);
        wait_done("post_reset");
        tests++;
        if (mbytes[0] !== 8'hA0 || mbytes[1] !== 8'h77 || n_start !== 1 || n_stop !== 1 || n_done !== 1 || n_wrr !== 1) begin
            fails++;
            $display("FAIL post_reset: bytes %h %h start=%0d stop=%0d done=%0d wr_ready=%0d required a0 77 1 1 1 1",
                     mbytes[0], mbytes[1], n_start, n_stop, n_done, n_wrr);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_probe();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Transaction-level I2C master controller. It generates SCL and the bit-timing counter, and issues START and STOP. It shifts out the address and write bytes itself. For read bytes it enables the byte receiver engine and multiplexes that engine's SDA drive onto the bus. A host issues one command per transaction (address, direction, length) and streams write/read bytes through valid/ready handshakes.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
CLK_DIV, CLK_FREQ / 200_000, clk cycles per SCL half-period (250 gives 100 kHz)
DIV_LEN, 16, width of clk_counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high when idle; command accepted when cmd_valid & cmd_ready
cmd_addr  in  7  7-bit slave address
cmd_rw  in  1  0 = write, 1 = read
cmd_len  in  4  data byte count 0..15; 0 = address-only probe
wr_data  in  8  write byte
wr_valid  in  1  write byte available
wr_ready  out  1  one-cycle pulse when wr_data is consumed
rd_data  out  8  received byte
rd_valid  out  1  one-cycle pulse, rd_data valid
busy  out  1  transaction in progress
done  out  1  one-cycle pulse after STOP completes
nack_err  out  1  address/write byte NACKed; held until next command accept
scl_o  out  1  SCL, 1 = released (open-drain)
sda_o  in  1  sampled SDA line
sda_t  out  1  SDA tristate, 1 = released
sda_i  out  1  SDA drive value when sda_t = 0
clk_counter  out  DIV_LEN  half-period timing counter, shared with receiver
rx  out  1  receiver enable, active-low
rx_data  in  8  receiver byte
rx_data_rdy  in  1  receiver byte ready, active-low
rx_ack  out  1  ACK value for receiver: 0 = ACK, 1 = NACK
rx_sda_t, rx_sda_i  in  1 each  receiver SDA drive, forwarded while in kRead

Behaviour:
- Reset values: scl_o=1, sda_t=1, sda_i=1, rx=1, rx_ack=1, clk_counter=0, busy=0, cmd_ready=1, wr_ready=0, rd_valid=0, done=0, nack_err=0, rd_data=0.
- Reset mid-transaction: return to kIdle in the same cycle, release SCL and SDA, generate no STOP.
- clk_counter: counts 0..CLK_DIV-1 while busy and wraps. scl_o toggles on each wrap outside START/STOP. Held at 0 in kIdle. Frozen during a write stall.
- Data change point: clk_counter == CLK_DIV/2 with SCL low.
- Sample point: clk_counter == CLK_DIV/2 with SCL high.
- kIdle: on command accept, latch addr/rw/len, clear nack_err, busy=1, go to kStart.
- kStart: sda driven 0 while SCL high for CLK_DIV cycles, then SCL low, then kAddr.
- kAddr: shift {addr, rw} MSB first, 8 bits.
- kAddrAck: release SDA and sample ACK.
  - sda_o = 1: nack_err=1, go to kStop.
  - len = 0: go to kStop.
  - Otherwise go to kWrite (rw=0) or kRead (rw=1).
- kWrite: at the first change point of each byte, consume wr_data and pulse wr_ready.
  - If wr_valid = 0 there, SCL is held low and the counter frozen until wr_valid = 1.
  - After the byte goes to kWriteAck: sample ACK; NACK sets nack_err and goes to kStop.
  - After the last byte goes to kStop.
- kRead: rx=0 and SDA muxed from rx_sda_t/rx_sda_i.
  - rx_ack = 0 for every byte except the last, which gets 1.
  - On the first clk where rx_data_rdy falls: rd_data = rx_data, rd_valid pulses.
  - rx goes to 1 during the last byte's ACK slot.
  - After the last ACK slot goes to kStop.
- kStop: SDA driven 0 during SCL low, SCL released, SDA released CLK_DIV/2 cycles later. Then done pulses, busy=0 and the FSM returns to kIdle.
- Remaining byte count: 4-bit down-counter, decrements per byte, end at 1.
- Ignored inputs: cmd_valid while busy; wr_valid outside kWrite.

Test Plan:
- Write addr 0x50, len 2, data 0x12, 0x34, slave ACKs all -> bus bytes 0xA0, 0x12, 0x34, START/STOP correct, 2 wr_ready pulses, done=1, nack_err=0.
- Write addr 0x3C, slave NACKs address -> nack_err=1, STOP issued, no wr_ready, done pulses once.
- Read addr 0x51, len 3, slave sends 0xDE, 0xAD, 0xBE -> rd_valid x3 with those values, rx_ack 0, 0, 1, first bus byte 0xA3, STOP.
- Probe addr 0x20 len 0 with ACK -> START, 0x40, ACK, STOP, nack_err=0.
- Write len 2 with wr_valid low 1000 cycles before byte 2 -> SCL stays low, clk_counter frozen, transfer resumes, 2nd byte correct.
- rst asserted mid-write -> next cycle scl_o=1, sda_t=1, busy=0, cmd_ready=1; new command proceeds normally.
